// File: rtl/rr_arb4_sel.sv
`timescale 1ns/1ps
// Four-requester round-robin arbiter driving a 2-to-4 enable decoder (sel -> a, sel_en -> e).
// Latency: req in cycle N -> registered sel/sel_en from cycle N+1; one dead cycle between any two grants.
// Backpressure: requesters hold req high; a grant ends on req drop or after HOLD_MAX cycles.
// Optional: define RR_ARB4_PRIO0_EN to make requester 0 urgent (always wins, never time-limited).
module rr_arb4_sel #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic       sel_en,
  output logic       expired
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit              LIMITED  = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       sel_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic             exp_nxt;
  logic [1:0]       win;
  logic             win_vld;
  logic             hold_hit;

  // Scan from ptr+3 down to ptr so the closest set bit to ptr is the last one written.
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        win     = ptr + 2'(k);
        win_vld = 1'b1;
      end
    end
`ifdef RR_ARB4_PRIO0_EN
    if (req[0]) begin
      win     = 2'd0;
      win_vld = 1'b1;
    end
`endif
  end

`ifdef RR_ARB4_PRIO0_EN
  assign hold_hit = LIMITED && (hold_cnt == HOLD_LIM) && (sel != 2'd0);
`else
  assign hold_hit = LIMITED && (hold_cnt == HOLD_LIM);
`endif

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    cnt_nxt   = hold_cnt;
    exp_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = GRANT;
          sel_nxt   = win;
          cnt_nxt   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          state_nxt = IDLE;
          ptr_nxt   = sel + 2'd1;
        end else if (hold_hit) begin
          state_nxt = IDLE;
          ptr_nxt   = sel + 2'd1;
          exp_nxt   = 1'b1;
        end else if (hold_cnt != CNT_SAT) begin
          cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 2'b00;
      ptr      <= 2'b00;
      hold_cnt <= '0;
      expired  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= cnt_nxt;
      expired  <= exp_nxt;
    end
  end

  // State is a flop, so sel_en is registered and drops with the async reset.
  assign sel_en = (state == GRANT);

endmodule
